// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, overflow/underflow error pulses, synchronous flush with
// acknowledge and a selectable registered or first-word-fall-through read port.
// All flags come from registers that are loaded from the next occupancy value,
// so they change on the same edge as count_o.
module fifo_sync_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   parameter int FWFT      = 0
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    flush_i,
   input  logic                    w_en_i,
   input  logic [DATA_W-1:0]       w_data_i,
   input  logic                    r_en_i,
   output logic [DATA_W-1:0]       r_data_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic                    almost_full_o,
   output logic                    almost_empty_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    flushed_o,
   output logic                    overflow_o,
   output logic                    underflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [CW-1:0] wPtr_q, wPtr_d;
   logic [CW-1:0] rPtr_q, rPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          almostFull_q, almostFull_d;
   logic          almostEmpty_q, almostEmpty_d;
   logic          flushed_q, flushed_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic          rdOk;
   logic          wrOk;
   logic [AW-1:0] wIdx;
   logic [AW-1:0] rIdx;

   // The pointer MSB is only a wrap bit; the low bits address the storage.
   assign wIdx = wPtr_q[AW-1:0];
   assign rIdx = rPtr_q[AW-1:0];

   // A read needs data; a write needs room, which a same-cycle read provides.
   always_comb begin
      rdOk = r_en_i && !empty_q;
      wrOk = w_en_i && (!full_q || rdOk);
   end

   // Next pointers, occupancy, flags and pulses; flush overrides everything.
   always_comb begin
      wPtr_d      = wPtr_q;
      rPtr_d      = rPtr_q;
      count_d     = count_q;
      flushed_d   = flush_i;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (flush_i) begin
         wPtr_d  = '0;
         rPtr_d  = '0;
         count_d = '0;
      end else begin
         if (wrOk) begin
            wPtr_d = wPtr_q + CW'(1);
         end
         if (rdOk) begin
            rPtr_d = rPtr_q + CW'(1);
         end
         count_d     = count_q + CW'(wrOk) - CW'(rdOk);
         overflow_d  = w_en_i && !wrOk;
         underflow_d = r_en_i && !rdOk;
      end
      full_d        = (count_d == CW'(DEPTH));
      empty_d       = (count_d == '0);
      almostFull_d  = (int'(count_d) >= AF_THRESH);
      almostEmpty_d = (int'(count_d) <= AE_THRESH);
   end

   // Control and status registers, cleared asynchronously by n_rst.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wPtr_q        <= '0;
         rPtr_q        <= '0;
         count_q       <= '0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         almostFull_q  <= (AF_THRESH == 0);
         almostEmpty_q <= 1'b1;
         flushed_q     <= 1'b0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         wPtr_q        <= wPtr_d;
         rPtr_q        <= rPtr_d;
         count_q       <= count_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         almostFull_q  <= almostFull_d;
         almostEmpty_q <= almostEmpty_d;
         flushed_q     <= flushed_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
      end
   end

   // Storage array is deliberately not reset; only accepted writes land here.
   always_ff @(posedge clk) begin
      if (wrOk && !flush_i) begin
         mem[wIdx] <= w_data_i;
      end
   end

   generate
      if (FWFT == 0) begin : gRegRead
         logic [DATA_W-1:0] rData_q;

         // Registered read port: the popped word appears the cycle after r_en.
         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               rData_q <= '0;
            end else if (flush_i) begin
               rData_q <= '0;
            end else if (rdOk) begin
               rData_q <= mem[rIdx];
            end
         end

         assign r_data_o = rData_q;
      end else begin : gFwftRead
         // Head of the queue is always visible; zero while there is nothing.
         assign r_data_o = empty_q ? '0 : mem[rIdx];
      end
   endgenerate

   assign full_o         = full_q;
   assign empty_o        = empty_q;
   assign almost_full_o  = almostFull_q;
   assign almost_empty_o = almostEmpty_q;
   assign count_o        = count_q;
   assign flushed_o      = flushed_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

endmodule
